ysyx_25040129_lsu: RTL

Memory-access stage directly downstream of the execute stage. Accepts one instruction at a time via valid/ready from execute and issues at most one load or store on a simple request/response data-memory bus. Loads are sign- or zero-extended, stores are lane-aligned with byte strobes, and non-memory instructions are forwarded unchanged. The result goes to write-back through a second valid/ready handshake.

---
 rtl/ysyx_25040129_lsu_pkg.sv | 47 ++++
 rtl/ysyx_25040129_lsu_fmt.sv | 44 ++++
 rtl/ysyx_25040129_lsu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the memory-access stage:
// load/store type encodings, FSM states and decode helpers.
package ysyx_25040129_lsu_pkg;

    localparam logic [2:0] LSU_RD_NONE = 3'd0;
    localparam logic [2:0] LSU_LB      = 3'd1;
    localparam logic [2:0] LSU_LH      = 3'd2;
    localparam logic [2:0] LSU_LW      = 3'd3;
    localparam logic [2:0] LSU_LBU     = 3'd4;
    localparam logic [2:0] LSU_LHU     = 3'd5;

    localparam logic [1:0] LSU_WR_NONE = 2'd0;
    localparam logic [1:0] LSU_SB      = 2'd1;
    localparam logic [1:0] LSU_SH      = 2'd2;
    localparam logic [1:0] LSU_SW      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_t;

    // Codes 6 and 7 decode as "no load".
    function automatic logic is_load(input logic [2:0] t);
        return (t >= LSU_LB) && (t <= LSU_LHU);
    endfunction

    // Natural alignment check for the access size implied by the type.
    function automatic logic misaligned(
        input logic [2:0] rd,
        input logic [1:0] wr,
        input logic [1:0] off
    );
        logic m;
        m = 1'b0;
        if (is_load(rd)) begin
            if (rd == LSU_LH || rd == LSU_LHU) m = off[0];
            else if (rd == LSU_LW)             m = |off;
        end else begin
            if (wr == LSU_SH)      m = off[0];
            else if (wr == LSU_SW) m = |off;
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_fmt.sv
// Combinational data formatting: store lane shift and strobes,
// load byte/half extraction with sign or zero extension.
module ysyx_25040129_lsu_fmt
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_type,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // Store path: move low bytes into their lanes, strobe those lanes.
    always_comb begin
        st_wdata = st_data << {st_off, 3'b000};
        st_wstrb = 4'b0000;
        case (st_type)
            LSU_SB:  st_wstrb = 4'b0001 << st_off;
            LSU_SH:  st_wstrb = 4'b0011 << st_off;
            LSU_SW:  st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    // Load path: bring the addressed lane down, then extend.
    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        ld_data  = ld_shift;
        case (ld_type)
            LSU_LB:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LSU_LH:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LSU_LBU: ld_data = {24'h0, ld_shift[7:0]};
            LSU_LHU: ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Memory-access stage: one load/store at a time on a simple
// request/response bus, non-memory ops forwarded to write-back.
module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_wdata,
    input  logic [2:0]        in_lsu_read,
    input  logic [1:0]        in_lsu_write,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    input  logic              in_csr_write,
    input  logic              in_ecall,
    input  logic              in_mret,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_csr_write,
    output logic              out_ecall,
    output logic              out_mret,
    output logic              out_misalign,
    output logic              out_bus_err
);

    lsu_state_t  state;
    logic [2:0]  r_read;
    logic [1:0]  r_off;
    logic        r_is_ld;

    logic        c_ld;
    logic        c_st;
    logic        c_mis;
    logic [1:0]  c_wr;
    logic [31:0] f_wdata;
    logic [3:0]  f_wstrb;
    logic [31:0] f_ldata;

    assign in_ready = (state == S_IDLE);

    // Decode the incoming op; a valid load masks any store type.
    always_comb begin
        c_ld  = is_load(in_lsu_read);
        c_wr  = c_ld ? LSU_WR_NONE : in_lsu_write;
        c_st  = (c_wr != LSU_WR_NONE);
        c_mis = misaligned(in_lsu_read, in_lsu_write, in_result[1:0]);
    end

    ysyx_25040129_lsu_fmt u_fmt (
        .st_off   (in_result[1:0]),
        .st_type  (c_wr),
        .st_data  (in_wdata),
        .st_wdata (f_wdata),
        .st_wstrb (f_wstrb),
        .ld_off   (r_off),
        .ld_type  (r_read),
        .ld_raw   (mem_rdata[31:0]),
        .ld_data  (f_ldata)
    );

    // Stage FSM with all bus and write-back outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            r_read        <= '0;
            r_off         <= '0;
            r_is_ld       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_pc        <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_csr_write <= 1'b0;
            out_ecall     <= 1'b0;
            out_mret      <= 1'b0;
            out_misalign  <= 1'b0;
            out_bus_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_read        <= in_lsu_read;
                        r_off         <= in_result[1:0];
                        r_is_ld       <= c_ld;
                        mem_addr      <= in_result[ADDR_W-1:0];
                        mem_wen       <= c_st;
                        mem_wdata     <= c_st ? f_wdata : '0;
                        mem_wstrb     <= f_wstrb;
                        out_data      <= in_result;
                        out_pc        <= in_pc;
                        out_rd        <= in_rd;
                        out_reg_write <= in_reg_write;
                        out_csr_write <= in_csr_write;
                        out_ecall     <= in_ecall;
                        out_mret      <= in_mret;
                        out_misalign  <= c_mis;
                        out_bus_err   <= 1'b0;
                        if ((c_ld || c_st) && !c_mis) begin
                            mem_req_valid <= 1'b1;
                            state         <= S_REQ;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_is_ld) out_data <= f_ldata;
                        out_bus_err <= mem_rsp_err;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
